dtack_wait_controller: RTL and testbench
========================================

DTACK_WAIT_CONTROLLER -- requirements
Module: dtack_wait_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of select/dtack channels (1..16).
REQ-002 SHALL have parameter WAIT_W, default 4: width of each per-channel wait-state field.
REQ-003 SHALL have parameter CH_MODE, default all-zero, 2*NUM_CH bits: per-channel mode. 0 = immediate, 1 = fixed wait, 2 = external dtack, 3 = reserved (treated as immediate).
REQ-004 SHALL have parameter CH_WAIT, default all-zero, WAIT_W*NUM_CH bits: per-channel wait-state count for mode 1.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 255: cycles from cycle start to bus error; 0 disables timeout.
REQ-006 Clk  input  1  system clock; all logic on the rising edge.
REQ-007 Reset_L  input  1  reset, asynchronous and active-low.
REQ-008 AS_L  input  1  68k address strobe; synchronous to Clk.
REQ-009 Select_H  input  NUM_CH  address-decoder selects, active-high.
REQ-010 ExtDtack_L  input  NUM_CH  per-channel device dtacks, active-low; used only in mode 2.
REQ-011 DtackOut_L  output  1  registered dtack to the CPU.
REQ-012 BerrOut_L  output  1  registered bus error to the CPU.
REQ-013 TimeoutCount  output  8  saturating count of timed-out cycles.
REQ-014 LastErrCh  output  4  channel index of the most recent timeout; 15 = no channel selected.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACK, ERR.
REQ-016 IDLE: DtackOut_L=1 and BerrOut_L=1; the first edge sampling AS_L=0 starts a cycle.
REQ-017 At cycle start SHALL latch the lowest-index asserted Select_H bit and its mode and wait value; the latch holds until IDLE is re-entered.
REQ-018 No select asserted at cycle start SHALL be treated as immediate mode, with channel index 15.
REQ-019 Immediate: IDLE -> ACK on the start edge, so DtackOut_L goes low 1 cycle after AS_L is first sampled low.
REQ-020 Fixed wait, W = CH_WAIT field: IDLE -> WAIT, then ACK after W further edges, so DtackOut_L goes low W+1 cycles after start. W=0 SHALL behave as immediate.
REQ-021 External: WAIT until the latched channel's ExtDtack_L is sampled 0, then ACK on that edge, so DtackOut_L is low 1 cycle later.
REQ-022 Timeout counter: SHALL clear at cycle start and increment each WAIT cycle. On reaching TIMEOUT_CYC in WAIT, go to ERR.
REQ-023 On entering ERR, BerrOut_L=0 with DtackOut_L=1, TimeoutCount increments (saturating at 255), and LastErrCh is loaded.
REQ-024 If dtack completion and timeout occur on the same edge, dtack SHALL win.
REQ-025 ACK/ERR SHALL hold their outputs until AS_L is sampled 1, then return to IDLE with outputs deasserted on that same edge.
REQ-026 AS_L sampled 1 while in WAIT SHALL abort to IDLE without asserting DtackOut_L or BerrOut_L.
REQ-027 DtackOut_L and BerrOut_L SHALL never be low simultaneously.
REQ-028 Select_H or ExtDtack_L changes on non-latched channels during a cycle SHALL have no effect.
REQ-029 Back-to-back cycles SHALL NOT be started in the same edge that returns to IDLE; a new cycle starts only after AS_L is sampled 1 then 0.

Reset
REQ-030 Reset_L=0 SHALL immediately force state IDLE, DtackOut_L=1, BerrOut_L=1, TimeoutCount=0, LastErrCh=15, counters=0, latched channel=15.
REQ-031 Reset asserted mid-cycle SHALL drop any active dtack or berr immediately, and SHALL NOT count as a timeout.
REQ-032 After reset release, a cycle with AS_L already low SHALL start on the first edge.

Structure
REQ-033 Mode encodings, FSM state encodings and the no-channel index 15 SHALL live in shared package dtack_pkg.
REQ-034 Channel priority select and mode/wait extraction SHALL be combinational within the top module.
REQ-035 The timeout counter SHALL be sub-module bus_timeout_counter, with clear, enable, terminal-count flag and a TIMEOUT_CYC parameter.

Verification
Bench configuration: NUM_CH=4, ch0 immediate, ch1 wait 3, ch2 external, ch3 wait 0, TIMEOUT_CYC=16.
REQ-036 Select_H=0001, AS_L low at edge 0 -> DtackOut_L low after edge 0; AS_L high at edge 5 -> DtackOut_L high after edge 5.
REQ-037 Select_H=0010 -> DtackOut_L low after edge 3 (4 cycles after start); Select_H=1000 -> low after edge 0.
REQ-038 Select_H=0100, ExtDtack_L[2] low at edge 7 -> DtackOut_L low after edge 7; ExtDtack_L[2] never low -> BerrOut_L low after edge 16, TimeoutCount=1, LastErrCh=2.
REQ-039 Select_H=0110 (ch1 and ch2) -> ch1 fixed-wait timing; ExtDtack_L[2] toggling has no effect.
REQ-040 Ch1 cycle with AS_L high at edge 2 -> abort, DtackOut_L never low; Reset_L low during ACK -> DtackOut_L=1 asynchronously, TimeoutCount=0.
REQ-041 300 timed-out ch2 cycles -> TimeoutCount saturates at 255, and DtackOut_L/BerrOut_L are never simultaneously low throughout.

Source files
------------

// File: rtl/dtack_pkg.sv
// Shared encodings for the 68k dtack/wait-state controller: channel modes,
// FSM states and the "no channel selected" index.
package dtack_pkg;

    typedef enum logic [1:0] {
        MODE_IMM = 2'd0,
        MODE_FIX = 2'd1,
        MODE_EXT = 2'd2,
        MODE_RSV = 2'd3
    } ch_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam int         CH_IDX_W    = 4;
    localparam logic [3:0] NO_CH       = 4'd15;
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Collapse the raw mode field into the behaviour actually used: the
    // reserved code and a zero-length fixed wait both act as immediate.
    function automatic ch_mode_e effective_mode(input logic [1:0] raw, input logic wait_zero);
        ch_mode_e m;
        case (raw)
            2'd1:    m = wait_zero ? MODE_IMM : MODE_FIX;
            2'd2:    m = MODE_EXT;
            default: m = MODE_IMM;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Bus-cycle timeout counter: cleared at cycle start, advanced once per wait
// cycle, flags the cycle on which the count reaches TIMEOUT_CYC.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal when this wait cycle is the TIMEOUT_CYC-th one; 0 disables.
    assign tc_o    = (TIMEOUT_CYC != 0) && (count_q == TC_VAL);
    assign count_o = count_q;

endmodule

// File: rtl/dtack_wait_controller.sv
// 68k DTACK/BERR generator: per-channel immediate, fixed-wait or external
// acknowledge, with a bus-error timeout and timeout statistics.
module dtack_wait_controller
    import dtack_pkg::*;
#(
    parameter int                       NUM_CH      = 4,
    parameter int                       WAIT_W      = 4,
    parameter logic [2*NUM_CH-1:0]      CH_MODE     = '0,
    parameter logic [WAIT_W*NUM_CH-1:0] CH_WAIT     = '0,
    parameter int                       TIMEOUT_CYC = 255
) (
    input  logic              Clk,
    input  logic              Reset_L,
    input  logic              AS_L,
    input  logic [NUM_CH-1:0] Select_H,
    input  logic [NUM_CH-1:0] ExtDtack_L,
    output logic              DtackOut_L,
    output logic              BerrOut_L,
    output logic [7:0]        TimeoutCount,
    output logic [3:0]        LastErrCh
);

    localparam int CNT_W = 16;

    logic [1:0]        ch_mode_raw [NUM_CH];
    logic [WAIT_W-1:0] ch_wait     [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_mode_raw[gi] = CH_MODE[2*gi +: 2];
            assign ch_wait[gi]     = CH_WAIT[WAIT_W*gi +: WAIT_W];
        end
    endgenerate

    state_e            state_q, state_d;
    logic [3:0]        ch_q, ch_d;
    ch_mode_e          mode_q, mode_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              dtack_q, dtack_d;
    logic              berr_q, berr_d;
    logic [7:0]        tcount_q, tcount_d;
    logic [3:0]        lasterr_q, lasterr_d;

    logic [3:0]        sel_idx;
    ch_mode_e          sel_mode;
    logic [WAIT_W-1:0] sel_wait;
    logic              ext_l;
    logic              start;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;
    logic [CNT_W-1:0]  cnt;
    logic              wait_done;
    logic              err_enter;

    // Lowest index wins: scan downward so the last hit is the lowest channel.
    always_comb begin
        sel_idx  = NO_CH;
        sel_mode = MODE_IMM;
        sel_wait = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (Select_H[i]) begin
                sel_idx  = CH_IDX_W'(i);
                sel_mode = effective_mode(ch_mode_raw[i], ch_wait[i] == '0);
                sel_wait = ch_wait[i];
            end
        end
    end

    // Only the latched channel's device dtack is observed.
    always_comb begin
        ext_l = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_IDX_W'(i)) begin
                ext_l = ExtDtack_L[i];
            end
        end
    end

    always_comb begin
        wait_done = 1'b0;
        case (mode_q)
            MODE_FIX: wait_done = ((cnt + CNT_W'(1)) == CNT_W'(wait_q));
            MODE_EXT: wait_done = !ext_l;
            default:  wait_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!AS_L) begin
                    start   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = (sel_mode == MODE_IMM) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (AS_L) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    // Completion beats timeout when both land on the same edge.
                    if (wait_done) begin
                        state_d = ST_ACK;
                    end else if (cnt_tc) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACK, ST_ERR: begin
                if (AS_L) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign err_enter = (state_q == ST_WAIT) && (state_d == ST_ERR);

    always_comb begin
        ch_d      = ch_q;
        mode_d    = mode_q;
        wait_d    = wait_q;
        tcount_d  = tcount_q;
        lasterr_d = lasterr_q;
        if (start) begin
            ch_d   = sel_idx;
            mode_d = sel_mode;
            wait_d = sel_wait;
        end
        if (err_enter) begin
            lasterr_d = ch_q;
            if (tcount_q != ERR_CNT_MAX) begin
                tcount_d = tcount_q + 8'd1;
            end
        end
        // Outputs are decoded from the next state so they are true flops.
        dtack_d = (state_d != ST_ACK);
        berr_d  = (state_d != ST_ERR);
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q   <= ST_IDLE;
            ch_q      <= NO_CH;
            mode_q    <= MODE_IMM;
            wait_q    <= '0;
            dtack_q   <= 1'b1;
            berr_q    <= 1'b1;
            tcount_q  <= '0;
            lasterr_q <= NO_CH;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            mode_q    <= mode_d;
            wait_q    <= wait_d;
            dtack_q   <= dtack_d;
            berr_q    <= berr_d;
            tcount_q  <= tcount_d;
            lasterr_q <= lasterr_d;
        end
    end

    bus_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk     (Clk),
        .rst_n   (Reset_L),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    assign DtackOut_L   = dtack_q;
    assign BerrOut_L    = berr_q;
    assign TimeoutCount = tcount_q;
    assign LastErrCh    = lasterr_q;

endmodule

// File: tb/tb_dtack_wait_controller.sv
// Directed bench for dtack_wait_controller: ch0 immediate, ch1 wait 3,
// ch2 external, ch3 wait 0, timeout 16.
module tb_dtack_wait_controller;

    logic       Clk;
    logic       Reset_L;
    logic       AS_L;
    logic [3:0] Select_H;
    logic [3:0] ExtDtack_L;
    logic       DtackOut_L;
    logic       BerrOut_L;
    logic [7:0] TimeoutCount;
    logic [3:0] LastErrCh;

    int n_checks = 0;
    int n_errors = 0;
    int overlap_cnt = 0;

    dtack_wait_controller #(
        .NUM_CH      (4),
        .WAIT_W      (4),
        .CH_MODE     (8'h64),
        .CH_WAIT     (16'h0030),
        .TIMEOUT_CYC (16)
    ) dut (
        .Clk          (Clk),
        .Reset_L      (Reset_L),
        .AS_L         (AS_L),
        .Select_H     (Select_H),
        .ExtDtack_L   (ExtDtack_L),
        .DtackOut_L   (DtackOut_L),
        .BerrOut_L    (BerrOut_L),
        .TimeoutCount (TimeoutCount),
        .LastErrCh    (LastErrCh)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (!DtackOut_L && !BerrOut_L) overlap_cnt++;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One bus cycle. Edge 0 is the start edge; AS_L is high at end_edge.
    // ext_edge: -1 never, -2 toggle every edge, else ExtDtack_L[2] low from that edge.
    // After the start edge Select_H is inverted to prove the latch holds.
    task automatic run_cycle(input logic [3:0] sel, input int ext_edge, input int end_edge,
                             input bit quiet,
                             output int dtack_at, output int berr_at, output int idle_after);
        dtack_at = -1;
        berr_at  = -1;
        for (int k = 0; k <= end_edge; k++) begin
            AS_L       = (k == end_edge);
            Select_H   = (k == 0) ? sel : ~sel;
            ExtDtack_L = 4'hF;
            if (ext_edge == -2) ExtDtack_L[2] = k[0];
            else if (ext_edge >= 0 && k >= ext_edge) ExtDtack_L[2] = 1'b0;
            @(posedge Clk); #1;
            if (!DtackOut_L && dtack_at < 0) dtack_at = k;
            if (!BerrOut_L && berr_at < 0) berr_at = k;
        end
        idle_after = (DtackOut_L && BerrOut_L) ? 1 : 0;
        AS_L       = 1'b1;
        Select_H   = 4'h0;
        ExtDtack_L = 4'hF;
        @(posedge Clk); #1;
        if (!quiet)
            $display("cycle sel=%b ext=%0d end=%0d -> dtack_edge=%0d berr_edge=%0d tocount=%0d lasterr=%0d",
                     sel, ext_edge, end_edge, dtack_at, berr_at, TimeoutCount, LastErrCh);
    endtask

    initial begin
        int d, b, idle, good;

        Reset_L    = 1'b0;
        AS_L       = 1'b1;
        Select_H   = 4'h0;
        ExtDtack_L = 4'hF;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_dtack", DtackOut_L, 1);
        check_eq("rst_berr", BerrOut_L, 1);
        check_eq("rst_tocount", TimeoutCount, 0);
        check_eq("rst_lasterr", LastErrCh, 15);
        Reset_L = 1'b1;
        @(posedge Clk); #1;

        run_cycle(4'b0001, -1, 5, 1'b0, d, b, idle);
        check_eq("ch0_dtack_edge", d, 0);
        check_eq("ch0_berr_edge", b, -1);
        check_eq("ch0_release", idle, 1);

        run_cycle(4'b0010, -1, 8, 1'b0, d, b, idle);
        check_eq("ch1_dtack_edge", d, 3);
        check_eq("ch1_release", idle, 1);

        run_cycle(4'b1000, -1, 4, 1'b0, d, b, idle);
        check_eq("ch3_dtack_edge", d, 0);

        run_cycle(4'b0000, -1, 3, 1'b0, d, b, idle);
        check_eq("nosel_dtack_edge", d, 0);

        run_cycle(4'b0100, 7, 10, 1'b0, d, b, idle);
        check_eq("ch2_ext_dtack_edge", d, 7);
        check_eq("ch2_ext_berr_edge", b, -1);

        run_cycle(4'b0100, -1, 20, 1'b0, d, b, idle);
        check_eq("ch2_to_berr_edge", b, 16);
        check_eq("ch2_to_dtack_edge", d, -1);
        check_eq("ch2_to_count", TimeoutCount, 1);
        check_eq("ch2_to_lasterr", LastErrCh, 2);
        check_eq("ch2_to_release", idle, 1);

        run_cycle(4'b0110, -2, 8, 1'b0, d, b, idle);
        check_eq("ch12_prio_dtack_edge", d, 3);
        check_eq("ch12_prio_berr_edge", b, -1);

        run_cycle(4'b0010, -1, 2, 1'b0, d, b, idle);
        check_eq("abort_dtack_edge", d, -1);
        check_eq("abort_berr_edge", b, -1);
        check_eq("abort_tocount", TimeoutCount, 1);

        // Reset in the middle of an acknowledged cycle
        Select_H = 4'b0001;
        AS_L     = 1'b0;
        @(posedge Clk); #1;
        check_eq("pre_rst_dtack", DtackOut_L, 0);
        #2 Reset_L = 1'b0;
        #1;
        check_eq("async_rst_dtack", DtackOut_L, 1);
        check_eq("async_rst_tocount", TimeoutCount, 0);
        check_eq("async_rst_lasterr", LastErrCh, 15);
        #1 Reset_L = 1'b1;
        @(posedge Clk); #1;
        check_eq("post_rst_first_edge_dtack", DtackOut_L, 0);
        AS_L     = 1'b1;
        Select_H = 4'h0;
        @(posedge Clk); #1;
        check_eq("post_rst_release", DtackOut_L, 1);
        $display("cycle reset-during-ack done tocount=%0d lasterr=%0d", TimeoutCount, LastErrCh);

        good = 0;
        for (int i = 0; i < 300; i++) begin
            run_cycle(4'b0100, -1, 17, 1'b1, d, b, idle);
            if (b == 16 && d == -1 && idle == 1) good++;
            if (i == 9) check_eq("sat_count_at_10", TimeoutCount, 10);
            $display("cycle timeout #%0d berr_edge=%0d tocount=%0d", i + 1, b, TimeoutCount);
        end
        check_eq("sat_good_cycles", good, 300);
        check_eq("sat_count", TimeoutCount, 255);
        check_eq("sat_lasterr", LastErrCh, 2);
        check_eq("no_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
